saph_ch_interp_pipe: RTL and testbench

Pipelined, multi-channel color interpolator with valid/ready flow control. Each accepted beat blends CH channels of W bits between `from` and `to` using one shared CW-bit coefficient. It is the parametrised successor of the single-channel 8-bit combinational interpolator, and sits in the pixel path between texture/vertex color fetch and the blend/write stage. The result latency is fixed at 2 cycles, and backpressure is supported without losing data.

---
 rtl/saph_ch_interp_pipe.sv | 101 ++++++++++
 tb/tb_saph_ch_interp_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/saph_ch_interp_pipe.sv
// Two-stage pipelined CH-channel color interpolator with valid/ready flow control.
// Define SAPH_INTERP_ROUND_EN for round-half-up; otherwise the result is truncated.
module saph_ch_interp_pipe #(
    parameter int CH = 4,
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH*W-1:0] in_from,
    input  logic [CH*W-1:0] in_to,
    input  logic [CW-1:0]   in_coeff,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH*W-1:0] out_q
);

    // Wide enough that f*2^CW + d*c' + rnd never wraps for any legal operands.
    localparam int AW = W + CW + 3;

`ifdef SAPH_INTERP_ROUND_EN
    localparam logic [AW-1:0] RND = AW'(1) << (CW - 1);
`else
    localparam logic [AW-1:0] RND = '0;
`endif

    logic          v1_reg;
    logic          v2_reg;
    logic          s1_load;
    logic          s2_load;
    logic [CW:0]   c_next;
    logic [CW:0]   c1_reg;

    assign in_ready  = !v1_reg || !v2_reg || out_ready;
    assign s1_load   = in_valid && in_ready;
    assign s2_load   = v1_reg && (!v2_reg || out_ready);
    assign out_valid = v2_reg;

    // Folding the MSB back in stretches 0..2^CW-1 onto 0..2^CW so c=max hits `to` exactly.
    assign c_next = {1'b0, in_coeff} + {{CW{1'b0}}, in_coeff[CW-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
        end else begin
            v1_reg <= s1_load || (v1_reg && !s2_load);
            v2_reg <= s2_load || (v2_reg && !out_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            c1_reg <= c_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : gen_ch
            logic [W-1:0]  f_in;
            logic [W-1:0]  t_in;
            logic [W:0]    d_next;
            logic [W-1:0]  f1_reg;
            logic [W:0]    d1_reg;
            logic [AW-1:0] acc_next;
            logic [W-1:0]  q_next;
            logic [W-1:0]  q2_reg;

            assign f_in   = in_from[gi*W +: W];
            assign t_in   = in_to[gi*W +: W];
            assign d_next = {1'b0, t_in} - {1'b0, f_in};

            // Two's-complement product modulo 2^AW equals the signed product here.
            assign acc_next = ({{(AW-W){1'b0}}, f1_reg} << CW)
                            + ({{(AW-W-1){d1_reg[W]}}, d1_reg} * {{(AW-CW-1){1'b0}}, c1_reg})
                            + RND;
            assign q_next   = W'(acc_next >> CW);

            always_ff @(posedge clk) begin
                if (s1_load) begin
                    f1_reg <= f_in;
                    d1_reg <= d_next;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q2_reg <= '0;
                end else if (s2_load) begin
                    q2_reg <= q_next;
                end
            end

            assign out_q[gi*W +: W] = q2_reg;
        end
    endgenerate

endmodule

// File: tb/tb_saph_ch_interp_pipe.sv
// Directed bench for saph_ch_interp_pipe: endpoints, channel independence,
// backpressure, full-rate streaming and asynchronous reset mid-stream.
module tb_saph_ch_interp_pipe;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [CH*W-1:0] in_from;
    logic [CH*W-1:0] in_to;
    logic [CW-1:0]   in_coeff;
    logic            out_valid;
    logic            out_ready;
    logic [CH*W-1:0] out_q;

    int n_tests = 0;
    int n_fail  = 0;

    logic [CH*W-1:0] exp_q [0:99];
    logic [CH*W-1:0] desc_exp;

    always #5 clk = ~clk;

    saph_ch_interp_pipe #(.CH(CH), .W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_from   (in_from),
        .in_to     (in_to),
        .in_coeff  (in_coeff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [31:0] f, input logic [31:0] t, input logic [7:0] c);
        in_valid = 1'b1;
        in_from  = f;
        in_to    = t;
        in_coeff = c;
    endtask

    // Reference: q = (f*256 + (t-f)*c' + rnd) / 256 with c' = c + (c >= 128).
    function automatic logic [7:0] ref_ch(input int f, input int t, input int c);
        int cp;
        int acc;
        cp  = (c >= 128) ? c + 1 : c;
        acc = f * 256 + (t - f) * cp;
`ifdef SAPH_INTERP_ROUND_EN
        acc = acc + 128;
`endif
        return 8'(acc / 256);
    endfunction

    function automatic logic [31:0] ref_beat(input logic [31:0] f, input logic [31:0] t,
                                             input logic [7:0] c);
        logic [31:0] r;
        r = '0;
        for (int ch = 0; ch < CH; ch++) begin
            r[ch*8 +: 8] = ref_ch(int'(f[ch*8 +: 8]), int'(t[ch*8 +: 8]), int'(c));
        end
        return r;
    endfunction

    // Beat presented in one cycle, captured by S1 at the next edge, visible after the one after.
    task automatic send_and_check(input string tag, input logic [31:0] f, input logic [31:0] t,
                                  input logic [7:0] c, input logic [31:0] expv);
        drive(f, t, c);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_q"}, out_q, expv);
        tick();
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rf;
        logic [31:0] rt;
        logic [7:0]  rc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_from   = '0;
        in_to     = '0;
        in_coeff  = '0;
        out_ready = 1'b1;
`ifdef SAPH_INTERP_ROUND_EN
        desc_exp = 32'hBF40_8020;
`else
        desc_exp = 32'hBF3F_8020;
`endif

        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_q", out_q, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        $display("[TB] reset state checked");
        rst_n = 1'b1;
        tick();

        send_and_check("endpoint_c0", 32'h1010_1010, 32'hF0F0_F0F0, 8'h00, 32'h1010_1010);
        $display("[TB] endpoint coeff=00 beat done");
        send_and_check("endpoint_cff", 32'h1010_1010, 32'hF0F0_F0F0, 8'hFF, 32'hF0F0_F0F0);
        $display("[TB] endpoint coeff=FF beat done");
        send_and_check("midpoint", 32'h0000_0000, 32'hFFFF_FFFF, 8'h80, 32'h8080_8080);
        $display("[TB] midpoint beat done");
        send_and_check("descending", 32'hFF00_8020, 32'h00FF_8020, 8'h40, desc_exp);
        $display("[TB] descending/per-channel beat done");

        // Backpressure: three beats offered while the sink stalls; only two fit.
        out_ready = 1'b0;
        drive(32'h0000_0000, 32'hFFFF_FFFF, 8'h80);
        #1;
        check("bp_ready_a", 32'(in_ready), 32'd1);
        tick();
        drive(32'h1010_1010, 32'hF0F0_F0F0, 8'hFF);
        #1;
        check("bp_ready_b", 32'(in_ready), 32'd1);
        tick();
        drive(32'h1010_1010, 32'hF0F0_F0F0, 8'h00);
        #1;
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_full_valid", 32'(out_valid), 32'd1);
        check("bp_full_q", out_q, 32'h8080_8080);
        tick();
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        check("bp_hold_q", out_q, 32'h8080_8080);
        tick();
        check("bp_hold2_q", out_q, 32'h8080_8080);
        out_ready = 1'b1;
        #1;
        check("bp_restart_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_out_b_valid", 32'(out_valid), 32'd1);
        check("bp_out_b_q", out_q, 32'hF0F0_F0F0);
        tick();
        check("bp_out_c_valid", 32'(out_valid), 32'd1);
        check("bp_out_c_q", out_q, 32'h1010_1010);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);
        $display("[TB] backpressure sequence done");

        // Full-rate stream: one new beat per cycle, results one edge behind capture.
        for (int i = 0; i <= 100; i++) begin
            if (i < 100) begin
                rf = $urandom;
                rt = $urandom;
                rc = 8'($urandom_range(0, 255));
                exp_q[i] = ref_beat(rf, rt, rc);
                drive(rf, rt, rc);
                #1;
                check("stream_in_ready", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i == 0) begin
                check("stream_first_latency", 32'(out_valid), 32'd0);
            end else begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_q", out_q, exp_q[i-1]);
            end
        end
        tick();
        check("stream_drained", 32'(out_valid), 32'd0);
        $display("[TB] 100-beat stream done");

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        drive(32'h1010_1010, 32'hF0F0_F0F0, 8'hFF);
        tick();
        drive(32'h0000_0000, 32'hFFFF_FFFF, 8'h80);
        tick();
        in_valid = 1'b0;
        check("rst_pre_valid", 32'(out_valid), 32'd1);
        check("rst_pre_ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_q", out_q, 32'd0);
        check("rst_async_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        check("rst_after_empty", 32'(out_valid), 32'd0);
        send_and_check("rst_new_beat", 32'hFF00_8020, 32'h00FF_8020, 8'h40, desc_exp);
        $display("[TB] mid-stream reset done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
